// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch producer:
// word width, NOP encoding and fetch FSM states.
package if_fetch_unit_pkg;

  localparam int WORD_LEN   = 16;
  localparam int PC_LEN_DEF = 16;

  localparam logic [WORD_LEN-1:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [PC_LEN_DEF-1:0] pc_inc(
    input logic [PC_LEN_DEF-1:0] pc
  );
    return pc + PC_LEN_DEF'(1);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read bus: req/addr from fetch,
// ack/data back from memory.
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int PC_LEN = PC_LEN_DEF
) ();

  logic                imem_req;
  logic [PC_LEN-1:0]   imem_addr;
  logic                imem_ack;
  logic [WORD_LEN-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// Prefetch buffer: synchronous FIFO with push, pop and
// a flush that overrides both.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q;
  logic [PW-1:0]    rd_d;
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    wr_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i &&
                   ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer: PC, imem req/ack sequencing,
// prefetch buffer and decode-side head presentation.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int PC_LEN     = PC_LEN_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                br_taken,
  input  logic [PC_LEN-1:0]   br_target,
  if_fetch_unit_if.master     imem,
  output logic                id_valid,
  output logic [WORD_LEN-1:0] id_instruction,
  output logic [PC_LEN-1:0]   id_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = WORD_LEN + PC_LEN;

  fetch_state_e      state_q;
  logic [PC_LEN-1:0] pc_q;
  logic [PC_LEN-1:0] pc_d;
  logic [PC_LEN-1:0] addr_q;
  logic              run_q;

  logic [CW-1:0]     count;
  logic              empty;
  logic [EW-1:0]     head;
  logic [EW-1:0]     entry;

  logic              req;
  logic              xfer;
  logic              push;
  logic              pop;

  // run_q keeps req low for the first cycle out of reset.
  assign req  = run_q &&
                ((state_q != S_REQ) ||
                 (count < CW'(FIFO_DEPTH)));
  assign xfer = req && imem.imem_ack;
  assign push = xfer && (state_q != S_DROP) && !br_taken;
  assign pop  = !empty && !freeze && !br_taken;

  assign entry = {imem.imem_data, pc_q + PC_LEN'(1)};

  assign imem.imem_req  = req;
  assign imem.imem_addr = (state_q == S_REQ) ? pc_q : addr_q;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (br_taken),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (entry),
    .count_o (count),
    .empty_o (empty),
    .head_o  (head)
  );

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      br_taken: pc_d = br_target;
      push:     pc_d = pc_q + PC_LEN'(1);
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // A redirect with a read in flight parks in S_DROP until
  // the stale word arrives, so at most one read is outstanding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_REQ;
      addr_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      unique case (state_q)
        S_REQ: begin
          if (req && !imem.imem_ack) begin
            addr_q  <= pc_q;
            state_q <= br_taken ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_ack) begin
            state_q <= S_REQ;
          end else if (br_taken) begin
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem.imem_ack) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign id_valid       = !empty;
  assign id_instruction = id_valid ? head[EW-1 -: WORD_LEN] : NOP;
  assign id_pc          = id_valid ? head[PC_LEN-1:0] : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table
// plus latency and reset-hold sequences.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        br_taken;
  logic [15:0] br_target;
  logic        id_valid;
  logic [15:0] id_instruction;
  logic [15:0] id_pc;

  int lat  = 0;
  int wcnt = 0;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_unit_if #(.PC_LEN(16)) bus ();

  if_fetch_unit #(
    .PC_LEN     (16),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .imem           (bus),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  // memory: ack after lat extra wait cycles, data = A000+addr
  assign bus.imem_ack  = bus.imem_req && (wcnt >= lat);
  assign bus.imem_data = 16'hA000 + bus.imem_addr;

  always @(posedge clk) begin
    if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  typedef struct {
    logic        rst;
    logic        frz;
    logic        br;
    logic [15:0] tgt;
    int          lat;
    logic        req;
    logic [15:0] addr;
    logic        val;
    logic [15:0] ins;
    logic [15:0] pc;
  } vec_t;

  localparam int NV = 34;
  vec_t v [NV];

  function automatic vec_t mk(
    input logic r, input logic f, input logic b,
    input logic [15:0] t, input int l,
    input logic q, input logic [15:0] a,
    input logic vl, input logic [15:0] in,
    input logic [15:0] p
  );
    vec_t x;
    x.rst = r; x.frz = f; x.br = b; x.tgt = t; x.lat = l;
    x.req = q; x.addr = a; x.val = vl; x.ins = in; x.pc = p;
    return x;
  endfunction

  int          got;
  logic [15:0] exp_ins;
  logic [15:0] exp_pc;
  logic        pend;
  logic [15:0] paddr;

  initial begin
    //        rst frz br tgt      lat  req addr     val ins      pc
    v[0]  = mk(0, 0, 0, 16'h0,    0,   0, 16'h0000, 0, 16'h0000, 16'h0000);
    v[1]  = mk(1, 0, 0, 16'h0,    0,   0, 16'h0000, 0, 16'h0000, 16'h0000);
    v[2]  = mk(1, 0, 0, 16'h0,    0,   1, 16'h0000, 0, 16'h0000, 16'h0000);
    v[3]  = mk(1, 0, 0, 16'h0,    0,   1, 16'h0001, 1, 16'hA000, 16'h0001);
    v[4]  = mk(1, 0, 0, 16'h0,    0,   1, 16'h0002, 1, 16'hA001, 16'h0002);
    v[5]  = mk(1, 0, 0, 16'h0,    0,   1, 16'h0003, 1, 16'hA002, 16'h0003);
    v[6]  = mk(1, 1, 0, 16'h0,    0,   1, 16'h0004, 1, 16'hA003, 16'h0004);
    v[7]  = mk(1, 1, 0, 16'h0,    0,   0, 16'h0005, 1, 16'hA003, 16'h0004);
    v[8]  = mk(1, 1, 0, 16'h0,    0,   0, 16'h0005, 1, 16'hA003, 16'h0004);
    v[9]  = mk(1, 1, 0, 16'h0,    0,   0, 16'h0005, 1, 16'hA003, 16'h0004);
    v[10] = mk(1, 1, 0, 16'h0,    0,   0, 16'h0005, 1, 16'hA003, 16'h0004);
    v[11] = mk(1, 0, 0, 16'h0,    0,   0, 16'h0005, 1, 16'hA003, 16'h0004);
    v[12] = mk(1, 0, 0, 16'h0,    0,   1, 16'h0005, 1, 16'hA004, 16'h0005);
    v[13] = mk(1, 0, 0, 16'h0,    2,   1, 16'h0006, 1, 16'hA005, 16'h0006);
    v[14] = mk(1, 0, 0, 16'h0,    2,   1, 16'h0006, 0, 16'h0000, 16'h0000);
    v[15] = mk(1, 0, 0, 16'h0,    2,   1, 16'h0006, 0, 16'h0000, 16'h0000);
    v[16] = mk(1, 1, 0, 16'h0,    2,   1, 16'h0007, 1, 16'hA006, 16'h0007);
    v[17] = mk(1, 0, 1, 16'h0040, 2,   1, 16'h0007, 1, 16'hA006, 16'h0007);
    v[18] = mk(1, 0, 0, 16'h0,    2,   1, 16'h0007, 0, 16'h0000, 16'h0000);
    v[19] = mk(1, 0, 0, 16'h0,    2,   1, 16'h0040, 0, 16'h0000, 16'h0000);
    v[20] = mk(1, 0, 0, 16'h0,    2,   1, 16'h0040, 0, 16'h0000, 16'h0000);
    v[21] = mk(1, 0, 0, 16'h0,    2,   1, 16'h0040, 0, 16'h0000, 16'h0000);
    v[22] = mk(1, 0, 0, 16'h0,    0,   1, 16'h0041, 1, 16'hA040, 16'h0041);
    v[23] = mk(1, 1, 1, 16'h0080, 0,   1, 16'h0042, 1, 16'hA041, 16'h0042);
    v[24] = mk(1, 0, 0, 16'h0,    0,   1, 16'h0080, 0, 16'h0000, 16'h0000);
    v[25] = mk(1, 0, 0, 16'h0,    2,   1, 16'h0081, 1, 16'hA080, 16'h0081);
    v[26] = mk(0, 0, 0, 16'h0,    2,   1, 16'h0081, 0, 16'h0000, 16'h0000);
    v[27] = mk(1, 0, 0, 16'h0,    0,   0, 16'h0000, 0, 16'h0000, 16'h0000);
    v[28] = mk(1, 0, 0, 16'h0,    0,   1, 16'h0000, 0, 16'h0000, 16'h0000);
    v[29] = mk(1, 0, 0, 16'h0,    0,   1, 16'h0001, 1, 16'hA000, 16'h0001);
    v[30] = mk(1, 0, 1, 16'hFFFF, 0,   1, 16'h0002, 1, 16'hA001, 16'h0002);
    v[31] = mk(1, 0, 0, 16'h0,    0,   1, 16'hFFFF, 0, 16'h0000, 16'h0000);
    v[32] = mk(1, 0, 0, 16'h0,    0,   1, 16'h0000, 1, 16'h9FFF, 16'h0000);
    v[33] = mk(1, 0, 0, 16'h0,    0,   1, 16'h0001, 1, 16'hA000, 16'h0001);

    rst = 1'b0; freeze = 1'b0; br_taken = 1'b0;
    br_target = 16'h0; lat = 0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      rst = v[i].rst; freeze = v[i].frz; br_taken = v[i].br;
      br_target = v[i].tgt; lat = v[i].lat;
      @(negedge clk);
      n_cmp++;
      if ({bus.imem_req, bus.imem_addr, id_valid,
           id_instruction, id_pc} !==
          {v[i].req, v[i].addr, v[i].val, v[i].ins, v[i].pc}) begin
        n_bad++;
        $display("FAIL vec%0d got req=%b addr=%h val=%b ins=%h pc=%h required req=%b addr=%h val=%b ins=%h pc=%h",
                 i, bus.imem_req, bus.imem_addr, id_valid,
                 id_instruction, id_pc, v[i].req, v[i].addr,
                 v[i].val, v[i].ins, v[i].pc);
      end
      @(posedge clk); #1;
    end

    // latency-3 stream: ordered delivery and stable address
    rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; lat = 2;
    got = 0; exp_ins = 16'hA001; pend = 1'b0; paddr = '0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      @(negedge clk);
      if (pend) begin
        n_cmp++;
        if (!(bus.imem_req && bus.imem_addr == paddr)) begin
          n_bad++;
          $display("FAIL addr_hold got req=%b addr=%h required req=1 addr=%h",
                   bus.imem_req, bus.imem_addr, paddr);
        end
      end
      pend  = bus.imem_req && !bus.imem_ack;
      paddr = bus.imem_addr;
      if (id_valid) begin
        exp_pc = exp_ins - 16'hA000 + 16'h0001;
        n_cmp++;
        if (id_instruction !== exp_ins || id_pc !== exp_pc) begin
          n_bad++;
          $display("FAIL lat_order got ins=%h pc=%h required ins=%h pc=%h",
                   id_instruction, id_pc, exp_ins, exp_pc);
        end
        exp_ins = exp_ins + 16'h0001;
        got++;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (got != 4) begin
      n_bad++;
      $display("FAIL lat_timeout got %0d deliveries required 4", got);
    end

    // reset held low: no request, nothing valid
    rst = 1'b0; lat = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.imem_req !== 1'b0 || id_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_hold%0d got req=%b val=%b required req=0 val=0",
                 c, bus.imem_req, id_valid);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL rel_idle got req=%b required req=0", bus.imem_req);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      n_bad++;
      $display("FAIL rel_first got req=%b addr=%h required req=1 addr=0000",
               bus.imem_req, bus.imem_addr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
